// File: rtl/bin_to_bcd_seq.sv
//------------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble), one
//   input bit per clock. Feeds the 8-digit seven-segment display driver, so the
//   digit outputs are registered and only change on the done cycle; the
//   display never sees a partially converted value.
//
// Parameters
//   IN_WIDTH : width of the unsigned binary operand (4..32, default 27).
//   DIGITS   : number of BCD digits; fixed at 8 to match the display driver.
//
// Ports
//   CLK            : system clock, rising-edge active
//   reset          : asynchronous active-low reset
//   start          : conversion request, honoured only when idle
//   value          : binary operand, captured on the accepted start
//   busy           : high while a conversion is running (IN_WIDTH cycles)
//   done           : one-cycle pulse when data_* / ovf are updated
//   ovf            : captured value was >= 100,000,000 (digits are mod 10^8)
//   data_7..data_0 : BCD digits, data_7 most significant
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module bin_to_bcd_seq #(
   parameter int IN_WIDTH = 27,
   parameter int DIGITS   = 8
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                start,
   input  logic [IN_WIDTH-1:0] value,
   output logic                busy,
   output logic                done,
   output logic                ovf,
   output logic [3:0]          data_7,
   output logic [3:0]          data_6,
   output logic [3:0]          data_5,
   output logic [3:0]          data_4,
   output logic [3:0]          data_3,
   output logic [3:0]          data_2,
   output logic [3:0]          data_1,
   output logic [3:0]          data_0
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(IN_WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   // One double-dabble step: every nibble >= 5 gets +3, then the BCD register
   // shifts left taking the next binary MSB. A carry out of the top nibble is
   // dropped, which is what makes the result value mod 10^8.
   function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b,
                                                input logic              msb);
      logic [BCD_W-1:0] c;
      c = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[4*i +: 4] >= 4'd5)
            c[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return (c << 1) | BCD_W'(msb);
   endfunction

   // Out-of-range detection. For IN_WIDTH < 27 the operand cannot reach
   // 10^8, so this folds to constant 0.
   function automatic logic ovf_of(input logic [IN_WIDTH-1:0] v);
      return (33'(v) >= 33'd100_000_000);
   endfunction

   logic [0:0]          state_q;
   logic [IN_WIDTH-1:0] bin_q;
   logic [BCD_W-1:0]    bcd_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                ovf_pend_q;
   logic [BCD_W-1:0]    data_q;
   logic                done_q;
   logic                ovf_q;

   logic [BCD_W-1:0]    bcd_next;
   logic [IN_WIDTH-1:0] bin_next;

   always_comb begin
      bcd_next = dd_step(bcd_q, bin_q[IN_WIDTH-1]);
      bin_next = bin_q << 1;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         data_q     <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == ST_IDLE) begin
            if (start) begin
               bin_q      <= value;
               bcd_q      <= '0;
               cnt_q      <= '0;
               ovf_pend_q <= ovf_of(value);
               state_q    <= ST_SHIFT;
            end
         end else begin
            bin_q <= bin_next;
            bcd_q <= bcd_next;
            cnt_q <= cnt_q + 1'b1;
            // Final shift: publish the fully shifted result in the same edge.
            if (cnt_q == LAST_CNT) begin
               data_q  <= bcd_next;
               ovf_q   <= ovf_pend_q;
               done_q  <= 1'b1;
               cnt_q   <= '0;
               state_q <= ST_IDLE;
            end
         end
      end
   end

   assign busy   = (state_q == ST_SHIFT);
   assign done   = done_q;
   assign ovf    = ovf_q;
   assign data_7 = data_q[31:28];
   assign data_6 = data_q[27:24];
   assign data_5 = data_q[23:20];
   assign data_4 = data_q[19:16];
   assign data_3 = data_q[15:12];
   assign data_2 = data_q[11:8];
   assign data_1 = data_q[7:4];
   assign data_0 = data_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
//------------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Directed self-checking bench for bin_to_bcd_seq (IN_WIDTH = 27). Expected
//   digit patterns are hand-computed BCD constants.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bin_to_bcd_seq;

   localparam int W = 27;

   logic         CLK;
   logic         reset;
   logic         start;
   logic [W-1:0] value;
   logic         busy;
   logic         done;
   logic         ovf;
   logic [3:0]   data_7, data_6, data_5, data_4, data_3, data_2, data_1, data_0;
   logic [31:0]  digits;

   int n_checks = 0;
   int n_fail   = 0;

   bin_to_bcd_seq #(.IN_WIDTH(W), .DIGITS(8)) dut (
      .CLK    (CLK),
      .reset  (reset),
      .start  (start),
      .value  (value),
      .busy   (busy),
      .done   (done),
      .ovf    (ovf),
      .data_7 (data_7),
      .data_6 (data_6),
      .data_5 (data_5),
      .data_4 (data_4),
      .data_3 (data_3),
      .data_2 (data_2),
      .data_1 (data_1),
      .data_0 (data_0)
   );

   assign digits = {data_7, data_6, data_5, data_4, data_3, data_2, data_1, data_0};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   // Counts edges (sampling 1ns after each) until done is seen, bounded.
   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(posedge CLK);
         #1;
         cyc++;
      end while (!done && cyc < 60);
   endtask

   // Single start pulse, then full check of latency, result, ovf and pulse width.
   task automatic convert(input string tag, input logic [W-1:0] v,
                          input logic [31:0] exp_bcd, input logic exp_ovf);
      int cyc;
      int bcnt;
      @(negedge CLK);
      value = v;
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      bcnt = busy ? 1 : 0;
      cyc  = 0;
      while (!done && cyc < 60) begin
         @(posedge CLK);
         #1;
         cyc++;
         if (busy) bcnt++;
      end
      check_eq({tag, "_latency"}, cyc, 27);
      check_eq({tag, "_busycycles"}, bcnt, 27);
      check_eq({tag, "_digits"}, digits, exp_bcd);
      check_eq({tag, "_ovf"}, {31'b0, ovf}, {31'b0, exp_ovf});
      @(posedge CLK);
      #1;
      check_eq({tag, "_donewidth"}, {31'b0, done}, 32'd0);
      check_eq({tag, "_hold"}, digits, exp_bcd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int ndone;
      reset = 1'b0;
      start = 1'b0;
      value = '0;

      // Power-on reset
      repeat (3) @(posedge CLK);
      #1;
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      check_eq("rst_done", {31'b0, done}, 32'd0);
      check_eq("rst_ovf", {31'b0, ovf}, 32'd0);
      check_eq("rst_digits", digits, 32'h0);
      @(negedge CLK);
      reset = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check_eq("idle_busy", {31'b0, busy}, 32'd0);

      // Main conversions
      convert("c12345678", 27'd12345678, 32'h12345678, 1'b0);
      convert("c0", 27'd0, 32'h00000000, 1'b0);
      convert("c99999999", 27'd99999999, 32'h99999999, 1'b0);
      convert("cmax", 27'd134217727, 32'h34217727, 1'b1);
      convert("c5", 27'd5, 32'h00000005, 1'b0);
      convert("cmax2", 27'd134217727, 32'h34217727, 1'b1);

      // Reset mid-conversion
      @(negedge CLK);
      value = 27'd12345678;
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      repeat (10) @(posedge CLK);
      #3;
      reset = 1'b0;
      #1;
      check_eq("midrst_busy", {31'b0, busy}, 32'd0);
      check_eq("midrst_done", {31'b0, done}, 32'd0);
      check_eq("midrst_ovf", {31'b0, ovf}, 32'd0);
      check_eq("midrst_digits", digits, 32'h0);
      @(negedge CLK);
      reset = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK);
         #1;
         if (done) ndone++;
      end
      check_eq("midrst_nodone", ndone, 0);
      check_eq("midrst_idle", {31'b0, busy}, 32'd0);

      // Start/value changes while busy are ignored
      @(negedge CLK);
      value = 27'd42;
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      value = 27'd777;
      check_eq("ign_busy", {31'b0, busy}, 32'd1);
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      cyc = 1;
      while (cyc < 25) begin
         @(posedge CLK);
         #1;
         cyc++;
      end
      check_eq("ign_mid_digits", digits, 32'h0);
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      check_eq("ign_c26_done", {31'b0, done}, 32'd0);
      check_eq("ign_c26_digits", digits, 32'h0);
      @(posedge CLK);
      #1;
      check_eq("ign_done", {31'b0, done}, 32'd1);
      check_eq("ign_digits", digits, 32'h00000042);
      @(posedge CLK);
      #1;
      check_eq("ign_no_restart", {31'b0, busy}, 32'd0);

      // Start held high, alternating operand
      @(negedge CLK);
      value = 27'd10;
      start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_done(cyc);
         check_eq($sformatf("held%0d_spacing", k), cyc, 28);
         check_eq($sformatf("held%0d_digits", k), digits,
                  (k % 2 == 0) ? 32'h00000010 : 32'h00000020);
         value = (k % 2 == 0) ? 27'd20 : 27'd10;
      end
      start = 1'b0;
      @(posedge CLK);
      #1;
      check_eq("held_end_done", {31'b0, done}, 32'd0);
      check_eq("held_end_busy", {31'b0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the 8-digit seven-segment display driver and feeds its data_7..data_0 nibble inputs. It converts an unsigned binary count into eight decimal digits. Its outputs are registered and change only on completion, so the display never shows intermediate values.

Parameters:
IN_WIDTH, 27, width of the binary input. Legal range 4..32. The default 27 covers 0..99,999,999.
DIGITS, 8, number of BCD digits produced. Fixed at 8 to match the display driver; other values are not supported.

Ports:
CLK  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  conversion request; sampled only in IDLE
value  input  IN_WIDTH  unsigned binary operand; captured on the accepted start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; data_* and ovf are updated in the same cycle
ovf  output  1  captured value was >= 100,000,000; held until the next done
data_7  output  4  BCD digit, 10^7 place (most significant)
data_6  output  4  BCD digit, 10^6 place
data_5  output  4  BCD digit, 10^5 place
data_4  output  4  BCD digit, 10^4 place
data_3  output  4  BCD digit, 10^3 place
data_2  output  4  BCD digit, 10^2 place
data_1  output  4  BCD digit, 10^1 place
data_0  output  4  BCD digit, 10^0 place (least significant)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, ovf=0; all data_* = 4'h0; internal shift register and bit counter cleared.
- Reset mid-conversion aborts the conversion; no done pulse is produced; outputs take their reset values.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge E:
  - load binary shift register with value; clear BCD working register; counter=0.
  - capture ovf_pending = (value >= 100,000,000). Constant 0 when IN_WIDTH < 27.
  - go to SHIFT; busy=1 from edge E.
- IDLE, start=0: hold.
- SHIFT, each edge:
  - every BCD nibble >= 5 gets +3;
  - the {BCD, binary} register shifts left by 1;
  - counter increments.
- Final shift at edge E+IN_WIDTH (counter == IN_WIDTH-1), same edge:
  - data_7..data_0 <= corrected and shifted BCD register;
  - ovf <= ovf_pending;
  - done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: busy high for exactly IN_WIDTH cycles. Results and done are visible IN_WIDTH cycles after the accepting edge.
- Carry out of the data_7 nibble is discarded, so the digits equal value mod 10^8. ovf flags this case.
- All digits are always valid BCD (0..9).
- start while busy=1 is ignored; no queueing. value changes while busy have no effect.
- start=1 during the done cycle: state is IDLE, so it is accepted. Back-to-back conversions run every IN_WIDTH+1 cycles... more precisely, one conversion can start on each done cycle.
- start held high continuously: a new conversion begins at each IDLE cycle.
- data_* and ovf are stable between done pulses; the display driver may sample them at any time.

Test Plan:
- Reset asserted mid-run, then released: all data_*=0, busy=0, done=0, ovf=0. No done pulse follows until a new start.
- value=12345678, start pulse: busy high 27 cycles; done at start-edge+27; data_7..data_0 = 1,2,3,4,5,6,7,8; ovf=0.
- value=0, then value=99999999: digits all 0, then all 9. ovf=0 in both cases; done pulse exactly one cycle each.
- value=134217727 (2^27-1): ovf=1; data_7..data_0 = 3,4,2,1,7,7,2,7 (value mod 10^8). A following conversion of value=5 clears ovf to 0 and gives data_0=5.
- start with value=42, then start pulses with value=777 at busy cycles 1 and 26: both ignored; result is 42. Outputs hold 0 (reset values) until done.
- start held high, value alternating 10/20 each accept: done pulses at regular spacing; results 10, 20, 10, ... each matching the value captured on its accepting edge; no lost or duplicated done.
